// File: rtl/twocomp_to_sm_serial_if.sv
// Request/result bundle for the serial two's-complement to sign-magnitude converter.
interface twocomp_to_sm_serial_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sm_out;
  logic             ovf;

  modport master (output start, din, input busy, done, sm_out, ovf);
  modport slave  (input start, din, output busy, done, sm_out, ovf);
endinterface

// File: rtl/twocomp_to_sm_serial.sv
// Bit-serial two's complement to sign-magnitude converter, magnitude processed LSB-first
// with the copy-until-first-one-then-invert rule; result presented with a one-cycle done.
module twocomp_to_sm_serial #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  twocomp_to_sm_serial_if.slave   bus
);
  localparam int MW = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             sign_q, sign_d;
  logic [MW-1:0]    shreg_q, shreg_d;
  logic [MW-1:0]    res_q, res_d;
  logic             seen_q, seen_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sm_q, sm_d;
  logic             ovf_q, ovf_d;

  logic             b;
  logic             out_bit;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    shreg_d   = shreg_q;
    res_d     = res_q;
    seen_d    = seen_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sm_d      = sm_q;
    ovf_d     = ovf_q;
    b         = shreg_q[0];
    out_bit   = sign_q ? (b ^ seen_q) : b;
    // New bit enters from the MSB side so the magnitude ends up in natural order.
    res_shift = {out_bit, res_q};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sign_d  = bus.din[WIDTH-1];
          shreg_d = bus.din[WIDTH-2:0];
          seen_d  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg_q >> 1;
        res_d   = res_shift[WIDTH-1:1];
        seen_d  = seen_q | b;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 2)) begin
          sm_d    = {sign_q, res_shift[WIDTH-1:1]};
          // A negative word with no one in its magnitude is -2^(WIDTH-1).
          ovf_d   = sign_q & ~(seen_q | b);
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sign_q  <= 1'b0;
      shreg_q <= '0;
      res_q   <= '0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sm_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      shreg_q <= shreg_d;
      res_q   <= res_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sm_q    <= sm_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.sm_out = sm_q;
  assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_twocomp_to_sm_serial.sv
// Directed and randomized checks of the serial converter at WIDTH=4 and WIDTH=8.
module tb_twocomp_to_sm_serial;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  twocomp_to_sm_serial_if #(.WIDTH(4)) if4 ();
  twocomp_to_sm_serial_if #(.WIDTH(8)) if8 ();

  twocomp_to_sm_serial #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  twocomp_to_sm_serial #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret as a signed integer, split into sign and absolute value.
  function automatic logic [32:0] model(input int w, input logic [31:0] d);
    int v;
    v = int'(d);
    if (d[w-1]) v = v - (1 << w);
    if (v == -(1 << (w - 1))) return {1'b1, d};
    if (v < 0) return {1'b0, 32'((1 << (w - 1)) + (-v))};
    return {1'b0, d};
  endfunction

  task automatic drive(input int w, input logic s, input logic [7:0] d);
    if (w == 4) begin if4.start = s; if4.din = d[3:0]; end
    else        begin if8.start = s; if8.din = d; end
  endtask

  function automatic logic busy_of(input int w);
    return (w == 4) ? if4.busy : if8.busy;
  endfunction
  function automatic logic done_of(input int w);
    return (w == 4) ? if4.done : if8.done;
  endfunction
  function automatic logic ovf_of(input int w);
    return (w == 4) ? if4.ovf : if8.ovf;
  endfunction
  function automatic logic [7:0] sm_of(input int w);
    return (w == 4) ? {4'd0, if4.sm_out} : if8.sm_out;
  endfunction

  // Called at #1 after an edge with the DUT idle; returns at #1 after the DONE->IDLE edge.
  task automatic convert(input int w, input logic [7:0] d, input logic [7:0] exp_sm,
                         input logic exp_ovf, input string tag);
    int lat;
    drive(w, 1'b1, d);
    @(posedge clk); #1;
    drive(w, 1'b0, d);
    check({tag, " busy_rise"}, busy_of(w), 1);
    lat = 0;
    while (!done_of(w) && lat < 4 * w) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, w - 1);
    check({tag, " sm_out"}, sm_of(w), exp_sm);
    check({tag, " ovf"}, ovf_of(w), exp_ovf);
    $display("W%0d din=%0h sm_out=%0h ovf=%0b latency=%0d", w, d, sm_of(w), ovf_of(w), lat);
    @(posedge clk); #1;
    check({tag, " done_fall"}, done_of(w), 0);
    check({tag, " busy_fall"}, busy_of(w), 0);
  endtask

  initial begin
    logic [32:0] m;
    logic [7:0]  d8;
    logic [3:0]  tbl_in  [6];
    logic [3:0]  tbl_out [6];
    int          ndone, first, last;

    tbl_in  = '{4'b0101, 4'b0111, 4'b1111, 4'b1001, 4'b1110, 4'b1000};
    tbl_out = '{4'b0101, 4'b0111, 4'b1001, 4'b1111, 4'b1010, 4'b1000};

    rst = 1'b1;
    drive(4, 1'b0, 8'd0);
    drive(8, 1'b0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset busy4", if4.busy, 0);
    check("reset done4", if4.done, 0);
    check("reset sm4", if4.sm_out, 0);
    check("reset ovf4", if4.ovf, 0);
    check("reset busy8", if8.busy, 0);
    check("reset sm8", if8.sm_out, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, WIDTH=4
    for (int i = 0; i < 6; i++)
      convert(4, {4'd0, tbl_in[i]}, {4'd0, tbl_out[i]}, tbl_in[i] == 4'b1000, "table4");

    // Exhaustive WIDTH=4 against the model
    for (int i = 0; i < 16; i++) begin
      m = model(4, 32'(i));
      convert(4, 8'(i), m[7:0], m[32], "exh4");
    end

    // Handshake timing with din=1101
    drive(4, 1'b1, 8'h0D);
    @(posedge clk); #1;
    drive(4, 1'b0, 8'h0D);
    check("hs busy_k", if4.busy, 1);
    check("hs done_k", if4.done, 0);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      check("hs done_mid", if4.done, 0);
      check("hs busy_mid", if4.busy, 1);
    end
    @(posedge clk); #1;
    check("hs done_k3", if4.done, 1);
    check("hs sm_k3", if4.sm_out, 4'b1011);
    check("hs busy_k3", if4.busy, 1);
    @(posedge clk); #1;
    check("hs done_k4", if4.done, 0);
    check("hs busy_k4", if4.busy, 0);
    $display("handshake din=1101 sm_out=%b", if4.sm_out);

    // Start during SHIFT is ignored
    drive(4, 1'b1, 8'h03);
    @(posedge clk); #1;
    drive(4, 1'b0, 8'h03);
    @(posedge clk); #1;
    drive(4, 1'b1, 8'h0F);
    @(posedge clk); #1;
    drive(4, 1'b0, 8'h0F);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        ndone++;
        check("ign sm", if4.sm_out, 4'b0011);
      end
    end
    check("ign ndone", ndone, 1);
    check("ign idle", if4.busy, 0);
    $display("ignored-start dones=%0d sm_out=%b", ndone, if4.sm_out);

    // Asynchronous reset during the second SHIFT cycle
    drive(4, 1'b1, 8'h0D);
    @(posedge clk); #1;
    drive(4, 1'b0, 8'h0D);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("rst busy", if4.busy, 0);
    check("rst done", if4.done, 0);
    check("rst sm", if4.sm_out, 0);
    check("rst ovf", if4.ovf, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if4.done) ndone++;
    end
    check("rst no_done", ndone, 0);
    $display("mid-reset dones_after=%0d", ndone);
    convert(4, 8'h0A, 8'h0E, 1'b0, "post_rst");

    // Continuous start: accepted at edges 1, 6, 11 -> done at 4, 9, 14
    drive(4, 1'b1, 8'h0C);
    ndone = 0; first = -1; last = -1;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (c == 12) drive(4, 1'b0, 8'h0C);
      if (if4.done) begin
        ndone++;
        check("cont sm", if4.sm_out, 4'b1100);
        check("cont ovf", if4.ovf, 0);
        if (first < 0) first = c;
        else check("cont period", c - last, 5);
        last = c;
        $display("continuous done at cycle %0d sm_out=%b", c, if4.sm_out);
      end
    end
    check("cont ndone", ndone, 3);
    check("cont first", first, 4);

    // WIDTH=8 directed and random
    convert(8, 8'h80, 8'h80, 1'b1, "w8_min");
    convert(8, 8'hFF, 8'h81, 1'b0, "w8_m1");
    convert(8, 8'h81, 8'hFF, 1'b0, "w8_m127");
    convert(8, 8'h7F, 8'h7F, 1'b0, "w8_p127");
    for (int i = 0; i < 24; i++) begin
      d8 = 8'($urandom_range(0, 255));
      m = model(8, {24'd0, d8});
      convert(8, d8, m[7:0], m[32], "w8_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/twocomp_to_sm_serial.md
Name: twocomp_to_sm_serial

Overview:
Bit-serial converter from WIDTH-bit two's complement to WIDTH-bit sign-magnitude. It is the inverse direction of the team's sign-magnitude-to-two's-complement converter. A word is captured on a start strobe and its magnitude is processed LSB-first, one bit per clock, using the copy-until-first-one-then-invert rule. The result is presented with a one-cycle done pulse. The block sits between datapath blocks that produce two's complement results and display/IO logic that expects sign-magnitude.

Parameters:
WIDTH, 4, word width in bits including the sign bit; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
din  input  WIDTH  two's complement operand; captured on the accepted start edge
busy  output  1  high while a conversion is in flight (SHIFT and DONE states)
done  output  1  one-cycle pulse; sm_out and ovf are valid from this cycle onward
sm_out  output  WIDTH  result: {sign, magnitude[WIDTH-2:0]}
ovf  output  1  high with done when din = -2^(WIDTH-1), which has no sign-magnitude encoding

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, sm_out=0, ovf=0; shift register, bit counter and seen_one flag cleared. Reset mid-conversion aborts it; no done is produced.
- FSM states: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - start=1 at edge k: latch sign=din[WIDTH-1] and shreg=din[WIDTH-2:0]; clear seen_one; counter=0; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT, one magnitude bit per edge, LSB first; b = shreg[0]:
  - out_bit = sign ? (b XOR seen_one) : b.
  - seen_one <= seen_one OR b, updated after out_bit is formed.
  - out_bit is shifted into the result register from the MSB side; shreg shifts right.
  - Counter increments.
  - On the edge that processes bit WIDTH-2: load sm_out={sign, result}; set ovf=sign AND NOT(seen_one OR b); set done=1; go to DONE.
- Latency: start sampled at edge k, done high from edge k+WIDTH-1 to edge k+WIDTH. For WIDTH=4 this is 3 cycles.
- DONE: lasts one cycle. done is cleared at the next edge and the FSM returns to IDLE. start during DONE is ignored.
- start during SHIFT or DONE is ignored and does not restart the conversion. din changes after capture have no effect.
- sm_out and ovf hold their last values until the next done. They are not cleared on a new start.
- Overflow case: din = 1 followed by WIDTH-1 zeros gives sm_out = the same pattern ("negative zero" encoding) with ovf=1.
- Zero: din=0 gives sm_out=0, ovf=0. Positive inputs pass through unchanged.
- Back-to-back: a start held high continuously is accepted again in the first IDLE cycle after DONE. Throughput is one conversion per WIDTH+1 cycles.
- No combinational path from any input to any output.

Test Plan:
- Exhaustive, WIDTH=4: apply all 16 din values 0000..1111, one conversion each, and check each result.
  - 0101->0101, 0111->0111, 1111->1001, 1001->1111, 1110->1010, 1000->1000 with ovf=1.
  - ovf=0 for every other value.
- Latency and handshake: start pulse at edge k with din=1101.
  - busy rises after edge k.
  - done is a single-cycle pulse after edge k+3 with sm_out=1011.
  - busy falls after edge k+4.
- Ignored start: with din=0011 in flight, pulse start with din=1111 during SHIFT. Required: sm_out=0011 and exactly one done pulse.
- Reset mid-operation: assert rst asynchronously (not on a clock edge) during the 2nd SHIFT cycle. Required:
  - All outputs go to 0 immediately.
  - No done appears.
  - A subsequent conversion of 1010 yields 1110.
- Continuous start: hold start=1 with din=1100 for 12 cycles. Required: done pulses every 5 cycles, each with sm_out=1100, ovf=0.
- Parameter sweep, WIDTH=8:
  - 0x80 -> 0x80 with ovf=1.
  - 0xFF -> 0x81.
  - 0x81 -> 0xFF.
  - 0x7F -> 0x7F.
  - Latency is 7 cycles.
